dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Sequencing controller for the 32-bit direct-mapped, read-only cache.
- Owns the tag and valid arrays, decides hit or miss for each CPU read, and runs line refills from main memory over a beat-based read interface.
- Drives the write port of the external cache data array, which stays in the parent.
- Keeps hit and miss counters used by the trace-driven benches.

Parameters:
- ADDR_W, 32, byte-address width.
- INDEX_W, 8, log2 of the number of lines (256 lines).
- OFF_W, 2, log2 of words per line (4 words of 32 bits each).
- CNT_W, 32, width of the hit and miss counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  read request; held high until cpu_ack.
- cpu_addr  in  ADDR_W  byte address; sampled when the request is accepted.
- cpu_ack  out  1  one-cycle pulse: request complete.
- cpu_hit  out  1  valid with cpu_ack: 1 = hit, 0 = serviced by refill.
- flush  in  1  one-cycle pulse: invalidate all lines.
- busy  out  1  high in any state other than IDLE.
- mem_req  out  1  line-read request to memory; held until the last beat.
- mem_addr  out  ADDR_W  line-aligned byte address (low OFF_W+2 bits = 0).
- mem_valid  in  1  one beat of line data is present on mem_data.
- mem_data  in  32  beat data, passed through to da_wdata.
- da_we  out  1  data-array write enable.
- da_index  out  INDEX_W  data-array line select (also the read select).
- da_word  out  OFF_W  data-array word select.
- da_wdata  out  32  data-array write data.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Address split: [1:0] is the byte offset (ignored), [OFF_W+1:2] is the word, then index, then tag = the remaining upper bits.
- Reset (asynchronous, immediate): state = IDLE.
  - All outputs are 0: cpu_ack, cpu_hit, busy, mem_req, mem_addr, da_we, da_index, da_word, da_wdata, hit_count, miss_count.
  - All valid bits are 0 and the beat counter is 0.
  - Reset mid-refill abandons the refill. Memory must tolerate mem_req dropping early.
- FSM states: IDLE, LOOKUP, REFILL, RESPOND, FLUSH.
- IDLE:
  - flush=1 → FLUSH. This takes priority over a simultaneous cpu_req.
  - Otherwise cpu_req=1 → latch cpu_addr and go to LOOKUP.
- LOOKUP (1 cycle):
  - Hit = the line's valid bit AND stored tag == latched tag.
  - On hit: cpu_ack=1, cpu_hit=1, hit_count+1, → IDLE. Hit latency is 2 cycles from the accepting edge to the ack cycle.
  - On miss: miss_count+1, beat counter = 0, → REFILL.
- REFILL:
  - mem_req=1 and mem_addr = {tag, index, zeros}.
  - Each cycle with mem_valid=1: da_we=1, da_word = beat counter, da_wdata = mem_data, counter+1.
  - Beats arrive in ascending word order. Gaps (mem_valid=0) are allowed.
  - On the beat where counter == 2^OFF_W − 1: write the tag and set the valid bit; next cycle mem_req=0 and state → RESPOND.
- RESPOND (1 cycle): cpu_ack=1, cpu_hit=0, → IDLE.
  - da_index and da_word point at the requested word, so the parent reads the refilled data in this cycle.
- FLUSH:
  - Walk the index from 0 to 2^INDEX_W−1, clearing one valid bit per cycle. This takes 256 cycles at the defaults, then → IDLE.
  - A flush pulse arriving outside IDLE is latched and serviced at the next return to IDLE, before any pending cpu_req.
- da_index and da_word are driven by the latched address in LOOKUP and RESPOND, so the data array can be read combinationally there.
- Counters saturate at all ones and never wrap.
- cpu_ack never asserts in two consecutive cycles. The CPU must hold cpu_req/cpu_addr stable until ack; cpu_req sampled high in the ack cycle is ignored (IDLE is re-entered next cycle).
- mem_valid outside REFILL is ignored.

Decomposition:
- Shared package dm_cache_pkg holds:
  - the field-width constants and a derived TAG_W;
  - the state enumeration;
  - tag/index/word extract functions, reused by the cache datapath and the benches.
- One natural sub-module: dm_tag_store. It holds the 2^INDEX_W × (TAG_W+1) tag/valid registers, with one combinational read port, one write port and a valid-clear port.
- FSM, beat counter and hit/miss counters stay in dm_cache_ctrl.

Test Plan:
- Cold miss:
  - Stimulus: after reset, cpu_req with addr 0x0000_1234; memory returns 4 beats, with a 1-cycle gap before beat 2.
  - Required: mem_addr = 0x0000_1230 and mem_req held for the whole refill; da_we pulses 4 times with words 0,1,2,3; then cpu_ack with cpu_hit=0; miss_count = 1.
- Re-hit:
  - Stimulus: same line at addr 0x0000_1238.
  - Required: cpu_ack 2 cycles after acceptance, cpu_hit=1, no mem_req; hit_count = 1.
- Conflict:
  - Stimulus: read 0x0000_1230, then 0x0004_1230 (same index, different tag), then 0x0000_1230 again.
  - Required: three misses, miss_count = 3.
- Flush:
  - Stimulus: fill 2 lines, pulse flush while a cpu_req is pending.
  - Required: busy for 256 cycles, the request waits; re-reading both lines gives 2 misses.
- Reset mid-refill:
  - Stimulus: assert rst after 2 beats.
  - Required: outputs are 0 immediately; the line is invalid; the next read of that address misses.
- Saturation:
  - Stimulus: force hit_count to all ones, then hit.
  - Required: hit_count stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared widths, state encoding and address-field helpers for the
// direct-mapped read-only cache controller and its benches.
package dm_cache_pkg;

    localparam int ADDR_W  = 32;
    localparam int INDEX_W = 8;
    localparam int OFF_W   = 2;
    localparam int CNT_W   = 32;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2;
    localparam int LINES   = 1 << INDEX_W;
    localparam int WORDS   = 1 << OFF_W;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [OFF_W-1:0]   word_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL,
        ST_RESPOND,
        ST_FLUSH
    } state_e;

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFF_W+2 +: INDEX_W];
    endfunction

    function automatic word_t addr_word(input addr_t a);
        return a[2 +: OFF_W];
    endfunction

    function automatic addr_t line_addr(input tag_t t, input index_t i);
        return {t, i, {(OFF_W+2){1'b0}}};
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (&c) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU, memory, data-array and statistics signals of the cache controller.
// slave = the controller, master = the surrounding CPU/memory/parent.
interface dm_cache_ctrl_if;
    import dm_cache_pkg::*;

    logic        cpu_req;
    addr_t       cpu_addr;
    logic        cpu_ack;
    logic        cpu_hit;
    logic        flush;
    logic        busy;
    logic        mem_req;
    addr_t       mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        da_we;
    index_t      da_index;
    word_t       da_word;
    logic [31:0] da_wdata;
    cnt_t        hit_count;
    cnt_t        miss_count;

    modport slave (
        input  cpu_req, cpu_addr, flush, mem_valid, mem_data,
        output cpu_ack, cpu_hit, busy, mem_req, mem_addr,
               da_we, da_index, da_word, da_wdata, hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_addr, flush, mem_valid, mem_data,
        input  cpu_ack, cpu_hit, busy, mem_req, mem_addr,
               da_we, da_index, da_word, da_wdata, hit_count, miss_count
    );

endinterface

// File: rtl/dm_tag_store.sv
// Tag and valid registers for every cache line: one combinational read port,
// one write port (tag + set valid) and one valid-clear port.
module dm_tag_store
    import dm_cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  index_t rd_index,
    output tag_t   rd_tag,
    output logic   rd_valid,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  logic   clr_en,
    input  index_t clr_index
);

    tag_t             tag_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (clr_en) valid_d[clr_index] = 1'b0;
        if (wr_en)  valid_d[wr_index]  = 1'b1;
    end

    // NOTE: only the valid bits are reset; a tag is never looked at while its valid bit is clear, so the tag array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) tag_q[wr_index] <= wr_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache sequencer: hit/miss decision, beat-based line
// refill into the parent's data array, full-cache flush and hit/miss counters.
module dm_cache_ctrl
    import dm_cache_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    dm_cache_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    addr_t       addr_q, addr_d;
    word_t       cnt_q, cnt_d;
    index_t      flush_idx_q, flush_idx_d;
    logic        flush_pend_q, flush_pend_d;

    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_hit_q, cpu_hit_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    addr_t       mem_addr_q, mem_addr_d;
    logic        da_we_q, da_we_d;
    index_t      da_index_q, da_index_d;
    word_t       da_word_q, da_word_d;
    logic [31:0] da_wdata_q, da_wdata_d;
    cnt_t        hit_count_q, hit_count_d;
    cnt_t        miss_count_q, miss_count_d;

    tag_t        rd_tag;
    logic        rd_valid;
    logic        lookup_hit;
    logic        last_beat;

    assign lookup_hit = rd_valid && (rd_tag == addr_tag(addr_q));
    assign last_beat  = (state_q == ST_REFILL) && bus.mem_valid && (cnt_q == word_t'(WORDS - 1));

    dm_tag_store u_tag_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (addr_index(addr_q)),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (last_beat),
        .wr_index  (addr_index(addr_q)),
        .wr_tag    (addr_tag(addr_q)),
        .clr_en    (state_q == ST_FLUSH),
        .clr_index (flush_idx_q)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        flush_idx_d  = flush_idx_q;
        flush_pend_d = flush_pend_q | bus.flush;
        cpu_ack_d    = 1'b0;
        cpu_hit_d    = 1'b0;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        da_we_d      = 1'b0;
        da_index_d   = da_index_q;
        da_word_d    = da_word_q;
        da_wdata_d   = da_wdata_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;

        unique case (state_q)
            ST_IDLE: begin
                // A flush pulse seen this cycle or latched earlier wins over a request.
                if (flush_pend_d) begin
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                    state_d      = ST_FLUSH;
                end else if (bus.cpu_req && !cpu_ack_q) begin
                    addr_d     = bus.cpu_addr;
                    da_index_d = addr_index(bus.cpu_addr);
                    da_word_d  = addr_word(bus.cpu_addr);
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    cpu_ack_d   = 1'b1;
                    cpu_hit_d   = 1'b1;
                    hit_count_d = sat_inc(hit_count_q);
                    state_d     = ST_IDLE;
                end else begin
                    miss_count_d = sat_inc(miss_count_q);
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = line_addr(addr_tag(addr_q), addr_index(addr_q));
                    state_d      = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (bus.mem_valid) begin
                    da_we_d    = 1'b1;
                    da_word_d  = cnt_q;
                    da_wdata_d = bus.mem_data;
                    cnt_d      = cnt_q + word_t'(1);
                    if (last_beat) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                // Point the data array back at the requested word for the ack cycle.
                cpu_ack_d = 1'b1;
                da_word_d = addr_word(addr_q);
                state_d   = ST_IDLE;
            end
            ST_FLUSH: begin
                flush_idx_d = flush_idx_q + index_t'(1);
                if (flush_idx_q == index_t'(LINES - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            flush_idx_q  <= '0;
            flush_pend_q <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_hit_q    <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            da_we_q      <= 1'b0;
            da_index_q   <= '0;
            da_word_q    <= '0;
            da_wdata_q   <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            flush_idx_q  <= flush_idx_d;
            flush_pend_q <= flush_pend_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_hit_q    <= cpu_hit_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            da_we_q      <= da_we_d;
            da_index_q   <= da_index_d;
            da_word_q    <= da_word_d;
            da_wdata_q   <= da_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_hit    = cpu_hit_q;
    assign bus.busy       = busy_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.da_we      = da_we_q;
    assign bus.da_index   = da_index_q;
    assign bus.da_word    = da_word_q;
    assign bus.da_wdata   = da_wdata_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: a line-level cache model predicts every
// response, refill address and data-array write; monitors compare as they appear.
module tb_dm_cache_ctrl;
    import dm_cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_cache_ctrl_if bus ();

    dm_cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        hit;
        logic [31:0] addr;
        logic [31:0] hits;
        logic [31:0] misses;
    } resp_t;

    typedef struct {
        logic [7:0]  idx;
        logic [1:0]  word;
        logic [31:0] data;
    } wr_t;

    int checks   = 0;
    int failures = 0;

    resp_t       resp_q [$];
    logic [31:0] mem_q  [$];
    wr_t         wr_q   [$];

    bit          m_valid [256];
    logic [19:0] m_tag   [256];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    int gap_beat    = -1;
    int abort_beats = 4;
    int beats_sent  = 0;
    bit prev_ack    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cpu_ack"},    bus.cpu_ack,    0);
        check({tag, "_cpu_hit"},    bus.cpu_hit,    0);
        check({tag, "_busy"},       bus.busy,       0);
        check({tag, "_mem_req"},    bus.mem_req,    0);
        check({tag, "_mem_addr"},   bus.mem_addr,   0);
        check({tag, "_da_we"},      bus.da_we,      0);
        check({tag, "_da_index"},   bus.da_index,   0);
        check({tag, "_da_word"},    bus.da_word,    0);
        check({tag, "_da_wdata"},   bus.da_wdata,   0);
        check({tag, "_hit_count"},  bus.hit_count,  0);
        check({tag, "_miss_count"}, bus.miss_count, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        resp_q.delete();
        mem_q.delete();
        wr_q.delete();
    endtask

    task automatic do_reset(input bit check_zero);
        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        if (check_zero) check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
    endtask

    // Model of one CPU read: plain direct-mapped lookup on addr >> 4 / addr >> 12.
    task automatic issue(input logic [31:0] addr, input bit do_flush);
        int          idx;
        logic [19:0] tag;
        bit          hit;
        bit          got;
        int          n;
        int          busy_run;
        @(posedge clk);
        #1;
        idx = int'((addr >> 4) & 32'hFF);
        tag = 20'(addr >> 12);
        if (do_flush) for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) begin
            if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
        end else begin
            if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            mem_q.push_back(addr & 32'hFFFF_FFF0);
        end
        resp_q.push_back('{hit: hit, addr: addr, hits: m_hits, misses: m_misses});

        bus.cpu_addr = addr;
        bus.cpu_req  = 1'b1;
        bus.flush    = do_flush;
        if (do_flush) begin
            @(posedge clk);
            #1 bus.flush = 1'b0;
            busy_run = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (bus.busy) busy_run++;
                else if (busy_run > 0) break;
            end
            check("flush_busy_cycles", busy_run, 256);
        end

        got = 1'b0;
        n   = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.cpu_ack) got = 1'b1;
        end
        check("ack_seen", got, 1);
        if (hit && !do_flush) check("hit_latency", n, 3);
        @(posedge clk);
        #1;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = $urandom;
        check("mem_q_drained", mem_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
    endtask

    // Memory side: checks the refill address and supplies beats with optional gaps.
    initial begin : mem_responder
        logic [31:0] line;
        logic [31:0] data;
        int          g;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_req) begin
                line = bus.mem_addr;
                if (mem_q.size() == 0) check("unexpected_mem_req", bus.mem_addr, 32'hDEAD_BEEF);
                else begin
                    line = mem_q.pop_front();
                    check("mem_addr", bus.mem_addr, line);
                end
                for (int b = 0; b < 4; b++) begin
                    if (b >= abort_beats) break;
                    g = (gap_beat < 0) ? int'($urandom_range(0, 2)) : ((b == gap_beat) ? 1 : 0);
                    repeat (g) @(negedge clk);
                    check("mem_req_held", bus.mem_req, 1);
                    data          = $urandom;
                    bus.mem_data  = data;
                    bus.mem_valid = 1'b1;
                    wr_q.push_back('{idx: line[11:4], word: 2'(b), data: data});
                    beats_sent++;
                    @(negedge clk);
                    bus.mem_valid = 1'b0;
                    bus.mem_data  = $urandom;
                end
                if (abort_beats >= 4) check("mem_req_dropped", bus.mem_req, 0);
                else for (int k = 0; k < 100 && !rst; k++) @(negedge clk);
            end
        end
    end

    initial begin : da_monitor
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst && bus.da_we) begin
                if (wr_q.size() == 0) check("unexpected_da_we", bus.da_we, 0);
                else begin
                    w = wr_q.pop_front();
                    check("da_we_index", bus.da_index, w.idx);
                    check("da_we_word",  bus.da_word,  w.word);
                    check("da_wdata",    bus.da_wdata, w.data);
                end
            end
        end
    end

    initial begin : resp_monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst && bus.cpu_ack) begin
                check("ack_not_back_to_back", prev_ack, 0);
                if (resp_q.size() == 0) check("unexpected_ack", bus.cpu_ack, 0);
                else begin
                    r = resp_q.pop_front();
                    check("cpu_hit",     bus.cpu_hit,    r.hit);
                    check("hit_count",   bus.hit_count,  r.hits);
                    check("miss_count",  bus.miss_count, r.misses);
                    check("ack_da_index", bus.da_index,  (r.addr >> 4) & 32'hFF);
                    check("ack_da_word",  bus.da_word,   (r.addr >> 2) & 32'h3);
                end
            end
            prev_ack = !rst && bus.cpu_ack;
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        do_reset(1'b1);

        // Cold miss with a one-cycle gap before beat 2, then a re-hit in the same line.
        gap_beat = 2;
        issue(32'h0000_1234, 1'b0);
        issue(32'h0000_1238, 1'b0);
        gap_beat = -1;

        // Conflict: same index, different tag, three misses.
        do_reset(1'b0);
        issue(32'h0000_1230, 1'b0);
        issue(32'h0004_1230, 1'b0);
        issue(32'h0000_1230, 1'b0);
        check("conflict_miss_total", bus.miss_count, 3);

        // Flush with a request pending: both filled lines miss afterwards.
        issue(32'h0000_2000, 1'b0);
        issue(32'h0000_3010, 1'b0);
        issue(32'h0000_2000, 1'b1);
        issue(32'h0000_3010, 1'b0);

        // Reset after two beats of a refill abandons the line.
        do_reset(1'b0);
        abort_beats = 2;
        beats_sent  = 0;
        mem_q.push_back(32'h0000_5670);
        @(posedge clk);
        #1;
        bus.cpu_addr = 32'h0000_5674;
        bus.cpu_req  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = (beats_sent >= 2);
        end
        check("abort_two_beats", ok, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check_outputs_zero("midreset");
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        abort_beats = 4;
        issue(32'h0000_5674, 1'b0);

        // Saturation: preload the hit counter at all ones, then hit.
        force dut.hit_count_q = '1;
        repeat (2) @(posedge clk);
        release dut.hit_count_q;
        m_hits = 32'hFFFF_FFFF;
        issue(32'h0000_5678, 1'b0);
        check("hit_count_saturated", bus.hit_count, 32'hFFFF_FFFF);

        // Random traffic over a small address pool, with occasional flushes.
        do_reset(1'b0);
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(1, 3)) << 12) | (32'($urandom_range(0, 3) * 37) << 4)
                | 32'($urandom_range(0, 15));
            issue(a, $urandom_range(0, 19) == 0);
        end
        check("final_resp_q_empty", resp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
